// File: rtl/binary_seq_transpose.sv
// binary_seq_transpose
// Collects SEQ_LEN consecutive CH-bit binary words and transposes them into
// CH per-channel time vectors. Channel c of the packed frame occupies bits
// [c*SEQ_LEN +: SEQ_LEN], and bit t of that slice is data_in[c] at time step t.
// The finished frame is held under a valid/ready handshake.
//
// Optional feature macro: BINARY_SEQ_TRANSPOSE_FRAME_CNT_EN
//   When defined, adds an 8-bit frame_cnt output that counts completed frame
//   handshakes (wraps at 255). flush does not clear it.
module binary_seq_transpose #(
    parameter int CH      = 16,
    parameter int SEQ_LEN = 30,
    parameter int CNT_W   = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic [CH-1:0]           data_in,
    input  logic                    data_in_valid,
    output logic                    data_in_ready,
    output logic [CH*SEQ_LEN-1:0]   frame_out,
    output logic                    frame_out_valid,
    input  logic                    frame_out_ready,
    output logic [CNT_W-1:0]        word_cnt,
    output logic                    overflow
`ifdef BINARY_SEQ_TRANSPOSE_FRAME_CNT_EN
    ,
    output logic [7:0]              frame_cnt
`endif
);

    localparam int FW    = CH * SEQ_LEN;
    localparam int IDX_W = $clog2(FW);
    localparam int CH_W  = $clog2(CH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SEQ_LEN - 1);

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_e;

    state_e             state_q,    state_d;
    logic [CNT_W-1:0]   word_cnt_q, word_cnt_d;
    logic [FW-1:0]      frame_q,    frame_d;
    logic               valid_q,    valid_d;
    logic               overflow_q, overflow_d;
    logic [IDX_W-1:0]   idx_s;
`ifdef BINARY_SEQ_TRANSPOSE_FRAME_CNT_EN
    logic [7:0]         frame_cnt_q, frame_cnt_d;
`endif

    // Next-state logic: flush wins over everything; otherwise collect words
    // until the frame is full, then hold it until the consumer takes it.
    always_comb begin
        state_d     = state_q;
        word_cnt_d  = word_cnt_q;
        frame_d     = frame_q;
        valid_d     = valid_q;
        overflow_d  = overflow_q;
        idx_s       = '0;
`ifdef BINARY_SEQ_TRANSPOSE_FRAME_CNT_EN
        frame_cnt_d = frame_cnt_q;
`endif
        if (flush) begin
            // Frame contents are intentionally retained; only control is cleared.
            state_d    = COLLECT;
            word_cnt_d = '0;
            valid_d    = 1'b0;
            overflow_d = 1'b0;
        end else begin
            // A word offered while not ready is lost; remember that sticky.
            if (data_in_valid && (state_q != COLLECT)) begin
                overflow_d = 1'b1;
            end else begin
                overflow_d = overflow_q;
            end
            case (state_q)
                COLLECT: begin
                    if (data_in_valid && (int'(word_cnt_q) < SEQ_LEN)) begin
                        // Scatter the word: bit c lands at time slot word_cnt of channel c.
                        for (int c = 0; c < CH; c++) begin
                            idx_s = IDX_W'(c * SEQ_LEN + int'(word_cnt_q));
                            frame_d[idx_s] = data_in[c[CH_W-1:0]];
                        end
                        if (word_cnt_q == LAST_CNT) begin
                            state_d = HOLD;
                            valid_d = 1'b1;
                        end else begin
                            word_cnt_d = word_cnt_q + CNT_W'(1);
                        end
                    end else begin
                        state_d = COLLECT;
                    end
                end
                HOLD: begin
                    if (frame_out_ready) begin
                        state_d    = COLLECT;
                        valid_d    = 1'b0;
                        word_cnt_d = '0;
`ifdef BINARY_SEQ_TRANSPOSE_FRAME_CNT_EN
                        frame_cnt_d = frame_cnt_q + 8'd1;
`endif
                    end else begin
                        state_d = HOLD;
                    end
                end
                default: begin
                    state_d    = COLLECT;
                    word_cnt_d = '0;
                    valid_d    = 1'b0;
                end
            endcase
        end
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= COLLECT;
            word_cnt_q  <= '0;
            frame_q     <= '0;
            valid_q     <= 1'b0;
            overflow_q  <= 1'b0;
`ifdef BINARY_SEQ_TRANSPOSE_FRAME_CNT_EN
            frame_cnt_q <= 8'd0;
`endif
        end else begin
            state_q     <= state_d;
            word_cnt_q  <= word_cnt_d;
            frame_q     <= frame_d;
            valid_q     <= valid_d;
            overflow_q  <= overflow_d;
`ifdef BINARY_SEQ_TRANSPOSE_FRAME_CNT_EN
            frame_cnt_q <= frame_cnt_d;
`endif
        end
    end

    // Ready is a pure decode of the state register so it never depends on
    // the downstream handshake.
    assign data_in_ready   = (state_q == COLLECT);
    assign frame_out       = frame_q;
    assign frame_out_valid = valid_q;
    assign word_cnt        = word_cnt_q;
    assign overflow        = overflow_q;
`ifdef BINARY_SEQ_TRANSPOSE_FRAME_CNT_EN
    assign frame_cnt       = frame_cnt_q;
`endif

endmodule

// File: doc/binary_seq_transpose.md
Name: binary_seq_transpose

Overview:
Downstream collector for the binary XNOR-popcount query stage. It gathers SEQ_LEN consecutive CH-bit binary result words, one per time step. It then transposes them into CH per-channel time vectors of SEQ_LEN bits each. The packed frame uses the same layout as the next binary stage's value input (channel c occupies bits [c*SEQ_LEN +: SEQ_LEN]), and the frame is presented through a valid/ready handshake.

Parameters:
- CH, 16, bits per input word (channels)
- SEQ_LEN, 30, words per frame (time steps)
- CNT_W, 5, width of the word counter; must satisfy 2^CNT_W >= SEQ_LEN

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous clear of the frame in progress
- data_in  input  CH  binary word for the current time step
- data_in_valid  input  1  data_in qualifier
- data_in_ready  output  1  block accepts a word this cycle
- frame_out  output  CH*SEQ_LEN  transposed frame, registered
- frame_out_valid  output  1  frame complete and stable
- frame_out_ready  input  1  consumer accepts the frame
- word_cnt  output  CNT_W  words written into the current frame
- overflow  output  1  sticky flag: a word was offered while not ready

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset values:
  - state = COLLECT
  - word_cnt = 0, frame_out = 0, frame_out_valid = 0, overflow = 0
  - data_in_ready = 1 (decoded from the state register)
- data_in_ready = (state == COLLECT). It is a combinational decode of the state register only and has no path from frame_out_ready.
- COLLECT state, on data_in_valid && data_in_ready:
  - For each c: frame_out[c*SEQ_LEN + word_cnt] <= data_in[c].
  - If word_cnt != SEQ_LEN-1: word_cnt increments.
  - If word_cnt == SEQ_LEN-1: next state is HOLD, word_cnt stays at SEQ_LEN-1, and frame_out_valid rises. frame_out_valid goes high the cycle after the last write (latency 1 from the final accepted word).
- COLLECT state, with no valid: all registers hold. Gaps of any length between words are legal.
- HOLD state:
  - frame_out and frame_out_valid are held stable; data_in_ready = 0.
  - On frame_out_ready = 1: frame_out_valid <= 0, word_cnt <= 0, state <= COLLECT. The first new word can be accepted on the following cycle.
  - frame_out is not cleared on handshake. Bits are overwritten by the next frame and are meaningful only while frame_out_valid = 1.
- Overflow:
  - Any cycle with data_in_valid = 1 and data_in_ready = 0 drops the word and sets overflow.
  - overflow clears only on reset or flush.
  - A word offered in the same cycle as the HOLD handshake is dropped and sets overflow.
- flush (highest priority after reset, any state):
  - Next state COLLECT; word_cnt <= 0, frame_out_valid <= 0, overflow <= 0.
  - frame_out contents are retained.
  - A data_in word in the same cycle is ignored and does not set overflow.
- Asynchronous reset in the middle of any state returns every register to its reset value immediately.
- frame_out_ready while frame_out_valid = 0 has no effect.

Optional Feature:
- Macro: BINARY_SEQ_TRANSPOSE_FRAME_CNT_EN.
- When defined:
  - Adds output frame_cnt (8 bits), reset value 0.
  - Increments on each frame_out_valid && frame_out_ready handshake and wraps from 255 to 0.
  - flush does not clear it.
- When undefined: the port and its counter are absent and all other behaviour is identical.

Test Plan:
- Pattern frame: 30 back-to-back words, 16'hFFFF for even t and 16'h0000 for odd t, frame_out_ready = 1.
  - frame_out_valid high exactly 1 cycle after word 29.
  - Every channel slice = 30'h15555555.
  - Valid drops the next cycle.
- Walking bit: word t = 16'h0001 << (t % 16).
  - Channel c slice has bits set at t = c and t = c+16 only; for example, channel 0 = 30'h00010001 and channel 15 = 30'h00008000.
- Backpressure: after a full frame, hold frame_out_ready = 0 for 5 cycles and drive data_in_valid = 1 with 16'hABCD.
  - data_in_ready = 0 throughout; frame_out is unchanged; overflow = 1.
  - Releasing ready completes the handshake; word_cnt = 0 the next cycle.
- Gapped input with flush:
  - 10 words with random 0–3 cycle gaps, then flush: word_cnt = 0, valid = 0, overflow = 0.
  - 30 new words then produce the correct new frame.
- Reset mid-HOLD: assert rst_n = 0 asynchronously while frame_out_valid = 1.
  - All outputs go to reset values before the next clock edge.
  - data_in_ready = 1 after rst_n is released.
- With the macro defined: 257 frames with immediate handshake → frame_cnt = 1 (wrapped); a flush leaves frame_cnt unchanged.
